// File: rtl/demux_stream_pkg.sv
// demux_stream shared definitions
// Mode encoding for the target-select mux.
package demux_stream_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_ROT  = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_stream_slot.sv
// demux_slot: one-entry output register
// Ports: clk, rst (sync, active-high), load/load_data from the demux,
// drain (consumer ready), valid/data toward the consumer.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A load wins over a drain in the same cycle: the consumer
  // takes the old word while the new one lands, with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N valid/ready demultiplexer
// Ports: clk, rst, en, mode, sel, in_* stream, out_* per channel, ptr.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [SEL_W-1:0]          ptr
);

  logic                rot;
  logic [SEL_W-1:0]    tgt;
  logic                accept;
  logic [CHANNELS-1:0] load;

  assign rot = (mode_e'(mode) == MODE_ROT);
  assign tgt = rot ? ptr : sel;

  // The target slot can take a word if it is empty or being
  // emptied this cycle; in_valid never feeds back into in_ready.
  assign in_ready = !rst && en &&
                    (!out_valid[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load      = '0;
    load[tgt] = accept;
  end

  // Power-of-two channel count: natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && rot) begin
      ptr <= ptr + SEL_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(in_data),
      .drain    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed stimulus with per-channel scoreboard
// Monitor pops expected words whenever a channel handshake fires.
module tb_demux_stream;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  ptr;

  int checks   = 0;
  int failures = 0;
  int st;

  logic [7:0] exp_q [N][$];
  logic [7:0] mon_e;

  always #5 clk = ~clk;

  demux_stream #(
    .WIDTH   (8),
    .CHANNELS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .ptr      (ptr)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic send(input  logic [7:0] d,
                      input  int         ch,
                      output int         stalls);
    stalls   = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 20) begin
        chk("send_timeout", 32'(stalls), 32'(0));
        break;
      end
    end
    if (stalls <= 20) exp_q[ch].push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ch%0d actual=%0h expected=none",
                     k, out_data[k*8 +: 8]);
          end else begin
            mon_e = exp_q[k].pop_front();
            chk($sformatf("ch%0d_data", k),
                32'(out_data[k*8 +: 8]), 32'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=done");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 4'h0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_ptr", 32'(ptr), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      send(8'hA0 + 8'(k), k, st);
      chk($sformatf("sweep_stall%0d", k), 32'(st), 32'h0);
      chk($sformatf("sweep_onehot%0d", k),
          32'(out_valid), 32'(4'b0001 << k));
    end

    out_ready = 4'b1011;
    sel       = 2'd2;
    send(8'h11, 2, st);
    chk("bp_first_stall", 32'(st), 32'h0);
    in_data  = 8'h22;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_valid2", 32'(out_valid[2]), 32'h1);
      chk("bp_hold2", 32'(out_data[23:16]), 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(8'h22, 2, st);
    chk("bp_release_stall", 32'(st), 32'h0);
    chk("bp_no_bubble", 32'(out_valid[2]), 32'h1);
    chk("bp_new_data", 32'(out_data[23:16]), 32'h22);

    mode = 1'b1;
    chk("rot_ptr_start", 32'(ptr), 32'h0);
    for (int i = 0; i < 6; i++) begin
      send(8'(i), i % 4, st);
      chk($sformatf("rot_stall%0d", i), 32'(st), 32'h0);
      chk($sformatf("rot_ptr%0d", i), 32'(ptr), 32'((i + 1) % 4));
    end

    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("en_in_ready", 32'(in_ready), 32'h0);
      chk("en_ptr", 32'(ptr), 32'h2);
    end
    chk("en_drained", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    sel      = 2'd3;
    send(8'h5A, 3, st);
    chk("addr_stall", 32'(st), 32'h0);
    chk("addr_ptr", 32'(ptr), 32'h2);
    chk("addr_valid", 32'(out_valid), 32'h8);
    chk("addr_data3", 32'(out_data[31:24]), 32'h5A);

    cyc(1);
    out_ready = 4'h0;
    sel = 2'd1;
    send(8'hC1, 1, st);
    sel = 2'd3;
    send(8'hC3, 3, st);
    chk("mid_full", 32'(out_valid), 32'hA);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_ptr", 32'(ptr), 32'h0);
    chk("mid_out_data", out_data, 32'h0);

    out_ready = 4'hF;
    cyc(3);
    for (int k = 0; k < N; k++)
      chk($sformatf("q%0d_empty", k), 32'(exp_q[k].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
